generic_demux: RTL and testbench
================================

# generic_demux

Registered, handshaked demultiplexer for the BP1 processor: routes one WIDTH-bit input stream to one of NUMBER output channels chosen per transfer by `in_sel`. It is the fan-out counterpart of the operand-select multiplexer and sits between a single producer (e.g. ALU/write-back result) and multiple consumers (register file, output port, memory write buffer). Each output has its own 2-entry FIFO, so one stalled consumer blocks only transfers addressed to it.

## Interface
- `WIDTH`, default 1: bits per data word.
- `NUMBER`, default 2: number of output channels, at least 2.
- `SELECT_W`, localparam `$clog2(NUMBER)`: select width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  demux accepts the word this cycle.
- `in_sel`  in  SELECT_W  destination channel index.
- `in_data`  in  WIDTH  data word.
- `out_valid`  out  NUMBER  per-channel word available.
- `out_ready`  in  NUMBER  per-channel consumer accepts.
- `out_data`  out  WIDTH x [NUMBER-1:0] unpacked  per-channel head word.
- `sel_err`  out  1  one-cycle pulse: out-of-range select was dropped.
- `drop_cnt`  out  8  saturating count of dropped transfers.

## Operation
- Input transfer occurs when `in_valid && in_ready` at a rising edge. Output transfer on channel k occurs when `out_valid[k] && out_ready[k]`.
- Each channel holds a 2-entry FIFO with pointer-based storage and a 2-bit count (0..2).
- `in_ready` is combinational from `in_sel` and FIFO counts only: 1 if `in_sel < NUMBER` and count[in_sel] < 2; 1 if `in_sel >= NUMBER`, so the word is consumed and dropped. It never depends on `out_ready`.
- `out_valid[k]` = (count[k] != 0). `out_data[k]` = FIFO head, or 0 when empty.
- Push and pop on the same channel in the same cycle: count is unchanged and order is preserved. This is legal at count 1 only. At count 2 no push is possible. At count 0 no pop is possible, and there is no bypass.
- Pushes to channel j are unaffected by a stalled channel k != j.
- Data order within a channel is strict FIFO. There is no ordering guarantee across channels.
- Reset: all counts and pointers 0, `out_valid` 0, `out_data` 0, `sel_err` 0, `drop_cnt` 0. A reset mid-transfer discards all buffered words, and any handshake in the reset cycle is ignored.

## Timing
- Latency: a word accepted at edge N is visible on `out_valid`/`out_data` after edge N, so it can be consumed at edge N+1.
- Throughput: 1 word/cycle sustained per channel when the consumer holds `out_ready` high.
- `sel_err` is registered: high for exactly the cycle after the dropping edge.
- `drop_cnt` increments at the same edge as the `sel_err` update and saturates at 255.

## Configuration
- `GENERIC_DEMUX_ERR_EN` defined: out-of-range select detection is active. `sel_err` pulses and `drop_cnt` counts as above.
- `GENERIC_DEMUX_ERR_EN` undefined:
  - Out-of-range words are still accepted and silently dropped.
  - `sel_err` and `drop_cnt` are tied to 0 and the counter logic is removed.
  - When NUMBER is a power of two, out-of-range selects cannot occur and the comparator is optimized away.

## Structure
- Shared package `bp1_pkg`: `DEMUX_DEPTH = 2` and `DROP_CNT_W = 8` constants.
- Sub-module `demux_slot`: one 2-entry FIFO with ports `clk`, `rst_n`, `push`, `push_data`, `pop`, `valid`, `full`, `head`. It is instantiated NUMBER times in a generate loop.
- Top level holds the select decode, `in_ready` mux and error logic.

## Test plan
- Reset then idle, NUMBER=4, WIDTH=8 → all `out_valid`=0, `out_data`=0, `in_ready`=1, `sel_err`=0, `drop_cnt`=0.
- Send 0xA1 sel=2, with `out_ready`=all 1 → `out_valid`=4'b0100 with `out_data[2]`=0xA1 exactly one cycle later, then cleared.
- Hold `out_ready[1]`=0 and send 0x11, 0x22, 0x33 to sel=1 → first two accepted, `in_ready`=0 on the third. Then send 0x44 sel=0 → accepted immediately. Release ready[1] → 0x11 then 0x22 in order.
- Sustained stream 0x00..0x0F to sel=3 with ready=1 → 16 words out on consecutive cycles, no bubbles, in order.
- NUMBER=3, `GENERIC_DEMUX_ERR_EN` defined, send sel=3 ×300 → `in_ready`=1, no `out_valid`, `sel_err` pulse per drop, `drop_cnt` saturates at 255.
- Assert `rst_n`=0 for one cycle with channel 0 holding 2 words → next cycle all counts empty, `out_valid`=0, and a subsequent push works normally.

Source files
------------

// File: rtl/bp1_pkg.sv
// Shared constants for BP1 datapath blocks.
package bp1_pkg;

  localparam int unsigned DEMUX_DEPTH = 2;
  localparam int unsigned DROP_CNT_W  = 8;

endpackage

// File: rtl/demux_slot.sv
// Two-entry pointer-based FIFO used as one output channel of generic_demux.
module demux_slot
  import bp1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEMUX_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign valid   = (cnt_q != 2'd0);
  assign full    = (cnt_q == 2'(DEMUX_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign head    = valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 2'd1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/generic_demux.sv
// Registered handshaked 1-to-NUMBER demultiplexer with a 2-entry FIFO per channel.
// Define GENERIC_DEMUX_ERR_EN to enable out-of-range select reporting (sel_err/drop_cnt).
module generic_demux
  import bp1_pkg::*;
#(
  parameter int unsigned  WIDTH    = 1,
  parameter int unsigned  NUMBER   = 2,
  localparam int unsigned SELECT_W = $clog2(NUMBER)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELECT_W-1:0]   in_sel,
  input  logic [WIDTH-1:0]      in_data,
  output logic [NUMBER-1:0]     out_valid,
  input  logic [NUMBER-1:0]     out_ready,
  output logic [WIDTH-1:0]      out_data [NUMBER-1:0],
  output logic                  sel_err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned        SLOTS   = 1 << SELECT_W;
  localparam logic [SELECT_W:0]  NUM_SEL = NUMBER[SELECT_W:0];

  logic              sel_ok;
  logic [NUMBER-1:0] full;
  logic [SLOTS-1:0]  full_ext;
  logic [NUMBER-1:0] push;
  logic [NUMBER-1:0] pop;

  // Constant-folds to 1 when NUMBER is a power of two.
  assign sel_ok = ({1'b0, in_sel} < NUM_SEL);

  always_comb begin
    full_ext               = '0;
    full_ext[NUMBER-1:0]   = full;
  end

  // Out-of-range words are always accepted so they can be dropped.
  assign in_ready = sel_ok ? !full_ext[in_sel] : 1'b1;

  always_comb begin
    push = '0;
    for (int k = 0; k < NUMBER; k++) begin
      push[k] = in_valid && sel_ok && (in_sel == SELECT_W'(k)) && !full[k];
    end
  end

  assign pop = out_valid & out_ready;

  for (genvar k = 0; k < NUMBER; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[k]),
      .push_data(in_data),
      .pop      (pop[k]),
      .valid    (out_valid[k]),
      .full     (full[k]),
      .head     (out_data[k])
    );
  end

`ifdef GENERIC_DEMUX_ERR_EN
  logic                  drop;
  logic                  sel_err_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign drop = in_valid && !sel_ok;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sel_err_q  <= drop;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sel_err  = sel_err_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign sel_err  = 1'b0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_generic_demux.sv
// Directed bench for generic_demux: NUMBER=4 and NUMBER=3 instances against a queue scoreboard.
module tb_generic_demux;

`ifdef GENERIC_DEMUX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready;
  logic [1:0] a_in_sel;
  logic [7:0] a_in_data;
  logic [3:0] a_out_valid, a_out_ready;
  logic [7:0] a_out_data [3:0];
  logic       a_sel_err;
  logic [7:0] a_drop_cnt;

  logic       b_in_valid, b_in_ready;
  logic [1:0] b_in_sel;
  logic [7:0] b_in_data;
  logic [2:0] b_out_valid, b_out_ready;
  logic [7:0] b_out_data [2:0];
  logic       b_sel_err;
  logic [7:0] b_drop_cnt;

  generic_demux #(.WIDTH(8), .NUMBER(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .sel_err(a_sel_err),
    .drop_cnt(a_drop_cnt)
  );

  generic_demux #(.WIDTH(8), .NUMBER(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .sel_err(b_sel_err),
    .drop_cnt(b_drop_cnt)
  );

  logic [7:0] qa [4][$];
  logic [7:0] qb [3][$];
  bit         exp_err;
  int         exp_cnt;
  int         vecs = 0;
  int         errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all outputs against the model, then advance model and DUT by one edge.
  task automatic step();
    bit a_rdy, b_rdy, b_drop;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("a_out_valid[%0d]", k), 32'(a_out_valid[k]), 32'(qa[k].size() != 0));
      chk($sformatf("a_out_data[%0d]", k), 32'(a_out_data[k]),
          (qa[k].size() != 0) ? 32'(qa[k][0]) : 32'd0);
    end
    a_rdy = (qa[a_in_sel].size() < 2);
    chk("a_in_ready", 32'(a_in_ready), 32'(a_rdy));
    chk("a_sel_err", 32'(a_sel_err), 32'd0);
    chk("a_drop_cnt", 32'(a_drop_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b_out_valid[%0d]", k), 32'(b_out_valid[k]), 32'(qb[k].size() != 0));
      chk($sformatf("b_out_data[%0d]", k), 32'(b_out_data[k]),
          (qb[k].size() != 0) ? 32'(qb[k][0]) : 32'd0);
    end
    b_rdy = (b_in_sel >= 2'd3) || (qb[b_in_sel].size() < 2);
    chk("b_in_ready", 32'(b_in_ready), 32'(b_rdy));
    chk("b_sel_err", 32'(b_sel_err), 32'(exp_err));
    chk("b_drop_cnt", 32'(b_drop_cnt), 32'(exp_cnt));

    if (!rst_n) begin
      for (int k = 0; k < 4; k++) qa[k].delete();
      for (int k = 0; k < 3; k++) qb[k].delete();
      exp_err = 1'b0;
      exp_cnt = 0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (a_out_ready[k] && qa[k].size() != 0) void'(qa[k].pop_front());
      if (a_in_valid && a_rdy) qa[a_in_sel].push_back(a_in_data);
      for (int k = 0; k < 3; k++)
        if (b_out_ready[k] && qb[k].size() != 0) void'(qb[k].pop_front());
      b_drop = b_in_valid && (b_in_sel >= 2'd3);
      if (b_in_valid && b_rdy && !b_drop) qb[b_in_sel].push_back(b_in_data);
      exp_err = ERR_EN && b_drop;
      if (ERR_EN && b_drop && exp_cnt < 255) exp_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_valid  = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = '0;
    b_in_valid  = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = 3'b111;
    exp_err     = 1'b0;
    exp_cnt     = 0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Single word to channel 2, consumed the cycle after acceptance.
    a_out_ready = 4'hF;
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'hA1;
    step();
    a_in_valid = 1'b0;
    step();
    step();

    // Stalled channel 1 fills; channel 0 stays open.
    a_out_ready = 4'b1101;
    a_in_valid = 1'b1; a_in_sel = 2'd1;
    a_in_data = 8'h11; step();
    a_in_data = 8'h22; step();
    a_in_data = 8'h33; step();
    a_in_sel = 2'd0; a_in_data = 8'h44; step();
    a_in_valid = 1'b0;
    step();
    a_out_ready = 4'hF;
    step();
    step();
    step();

    // Back-to-back stream on channel 3.
    a_in_valid = 1'b1; a_in_sel = 2'd3;
    for (int i = 0; i < 16; i++) begin
      a_in_data = 8'(i);
      step();
    end
    a_in_valid = 1'b0;
    step();
    step();

    // NUMBER=3: out-of-range select repeatedly dropped; counter saturates.
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hEE;
    for (int i = 0; i < 300; i++) step();
    b_in_sel = 2'd2; b_in_data = 8'h5C;
    step();
    b_in_valid = 1'b0;
    step();
    step();

    // Mid-stream reset with channel 0 full; reset-cycle handshake ignored.
    a_out_ready = 4'h0;
    a_in_valid = 1'b1; a_in_sel = 2'd0;
    a_in_data = 8'hC1; step();
    a_in_data = 8'hC2; step();
    rst_n = 1'b0; a_in_data = 8'h77;
    step();
    rst_n = 1'b1; a_in_valid = 1'b0;
    step();
    a_out_ready = 4'hF;
    a_in_valid = 1'b1; a_in_data = 8'h5A;
    step();
    a_in_valid = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
